// File: rtl/proc_pkg.sv
// proc_pkg
//   Shared definitions for param_processor: opcode values, FSM state
//   encoding and helpers that derive instruction-field positions from
//   the data width and register address width.
//   No ports (package).
package proc_pkg;

  // Opcode values (instruction bits [DATA_W-1 -: 3])
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_MVI = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Instruction phases; T0 doubles as idle/fetch
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // MSB of the 3-bit opcode field
  function automatic int op_msb(input int data_w);
    return data_w - 1;
  endfunction

  // MSB of the Rx field
  function automatic int rx_msb(input int data_w);
    return data_w - 4;
  endfunction

  // MSB of the Ry field
  function automatic int ry_msb(input int data_w, input int reg_aw);
    return data_w - 4 - reg_aw;
  endfunction

  // Width of the zero-extended immediate (overlaps Ry and below)
  function automatic int imm_w(input int data_w, input int reg_aw);
    return data_w - 3 - reg_aw;
  endfunction

endpackage

// File: rtl/proc_alu.sv
// proc_alu
//   Combinational ALU for param_processor.
//   Ports:
//     a_i      [DATA_W-1:0]  first operand (latched A register)
//     b_i      [DATA_W-1:0]  second operand (bus value, i.e. Ry)
//     op_i     [2:0]         opcode
//     result_o [DATA_W-1:0]  result, modulo 2^DATA_W
//     carry_o                add carry-out / sub borrow; 0 for logic ops
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o
);

  // One extra bit holds the carry (add) or borrow (sub); for a subtraction
  // of zero-extended operands the top bit is set exactly when a < b.
  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};

  // Operation select
  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = sum_s[DATA_W-1:0];
        carry_o  = sum_s[DATA_W];
      end
      OP_SUB: begin
        result_o = diff_s[DATA_W-1:0];
        carry_o  = diff_s[DATA_W];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_processor.sv
// param_processor
//   Parametrised multicycle processor. One instruction per run handshake;
//   the shared bus is a mux driven from state, IR and register file.
//   Optional feature macro: PROC_FLAGS_EN adds zero/carry flag registers
//   and the flag_z/flag_c ports.
//   Ports:
//     clock              rising-edge clock
//     resetn             synchronous reset, active HIGH despite the name
//     run                start request, sampled only in T0
//     iin  [DATA_W-1:0]  instruction word, captured with run in T0
//     done               high during the final cycle of each instruction
//     bus  [DATA_W-1:0]  current internal bus value
//     flag_z, flag_c     result-zero / carry-borrow (PROC_FLAGS_EN only)
//   DATA_W must be at least 3 + 2*REG_AW + 1; REG_CNT a power of two >= 2.
module param_processor
  import proc_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int REG_CNT = 8,
  localparam int REG_AW  = $clog2(REG_CNT)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] iin,
  output logic              done,
  output logic [DATA_W-1:0] bus
`ifdef PROC_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  localparam int OP_MSB = op_msb(DATA_W);
  localparam int RX_MSB = rx_msb(DATA_W);
  localparam int RY_MSB = ry_msb(DATA_W, REG_AW);
  localparam int IMM_W  = imm_w(DATA_W, REG_AW);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  g_q, g_d;
  logic [DATA_W-1:0]  regs_q [REG_CNT];

  logic [2:0]         opcode_s;
  logic [REG_AW-1:0]  rx_s;
  logic [REG_AW-1:0]  ry_s;
  logic [DATA_W-1:0]  imm_s;
  logic               is_alu_s;
  logic [DATA_W-1:0]  bus_s;
  logic               done_s;
  logic               rf_we_s;
  logic [DATA_W-1:0]  alu_res_s;
  logic               alu_carry_s;

  // Instruction field decode from the held IR
  assign opcode_s = ir_q[OP_MSB -: 3];
  assign rx_s     = ir_q[RX_MSB -: REG_AW];
  assign ry_s     = ir_q[RY_MSB -: REG_AW];
  assign imm_s    = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};

  // Classify opcodes that take the three-step ALU path
  always_comb begin
    is_alu_s = 1'b0;
    case (opcode_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_alu_s = 1'b1;
      default:                               is_alu_s = 1'b0;
    endcase
  end

  // Bus mux and done: purely a function of state, IR and registers
  always_comb begin
    bus_s  = '0;
    done_s = 1'b0;
    case (state_q)
      T0: begin
        bus_s  = '0;
        done_s = 1'b0;
      end
      T1: begin
        case (opcode_s)
          OP_MV: begin
            bus_s  = regs_q[ry_s];
            done_s = 1'b1;
          end
          OP_MVI: begin
            bus_s  = imm_s;
            done_s = 1'b1;
          end
          OP_OUT: begin
            bus_s  = regs_q[rx_s];
            done_s = 1'b1;
          end
          default: begin
            bus_s  = regs_q[rx_s];
            done_s = 1'b0;
          end
        endcase
      end
      T2: begin
        bus_s  = regs_q[ry_s];
        done_s = 1'b0;
      end
      T3: begin
        bus_s  = g_q;
        done_s = 1'b1;
      end
      default: begin
        bus_s  = '0;
        done_s = 1'b0;
      end
    endcase
  end

  assign bus  = bus_s;
  assign done = done_s;

  // In T2 the bus carries Ry, so the second operand is simply the bus
  proc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (a_q),
    .b_i      (bus_s),
    .op_i     (opcode_s),
    .result_o (alu_res_s),
    .carry_o  (alu_carry_s)
  );

  // Next-state, IR/A/G capture and register-write enable
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    g_d     = g_q;
    rf_we_s = 1'b0;
    case (state_q)
      T0: begin
        if (run) begin
          ir_d    = iin;
          state_d = T1;
        end else begin
          state_d = T0;
        end
      end
      T1: begin
        if (is_alu_s) begin
          a_d     = bus_s;
          state_d = T2;
        end else begin
          rf_we_s = (opcode_s != OP_OUT);
          state_d = T0;
        end
      end
      T2: begin
        g_d     = alu_res_s;
        state_d = T3;
      end
      T3: begin
        rf_we_s = 1'b1;
        state_d = T0;
      end
      default: begin
        state_d = T0;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
    end
  end

  // Register file; Rx is always written from the bus value
  always_ff @(posedge clock) begin
    if (resetn) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_we_s) begin
      regs_q[rx_s] <= bus_s;
    end
  end

`ifdef PROC_FLAGS_EN
  logic flag_z_q, flag_z_d;
  logic flag_c_q, flag_c_d;

  // Flags follow the ALU result only on the T2->T3 edge
  always_comb begin
    if (state_q == T2) begin
      flag_z_d = (alu_res_s == '0);
      flag_c_d = alu_carry_s;
    end else begin
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
    end
  end

  // Flag registers
  always_ff @(posedge clock) begin
    if (resetn) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`else
  // Carry has no consumer without flags
  logic unused_carry_s;
  assign unused_carry_s = alu_carry_s;
`endif

endmodule

// File: doc/param_processor.md
# param_processor

Parametrised successor to the 16-bit multicycle processor. It executes one instruction word per `run` handshake, with register count and data width set by parameters. It adds an explicit `run`/`done` handshake, logic opcodes and an output instruction. It sits between the instruction source (bench, ROM or sequencer) and the shared data `bus`, which is observed for debug and result capture.

## Interface
- `DATA_W`, 16: data, register, bus and instruction width. Constraint: `DATA_W >= 3 + 2*REG_AW + 1`.
- `REG_CNT`, 8: number of general registers R0..R(REG_CNT-1). Power of two, minimum 2.
- `REG_AW`, `$clog2(REG_CNT)`: register address width. Derived, not overridden.

Ports:
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  synchronous, active-high reset.
- `run`  in  1  start request, sampled only in T0.
- `iin`  in  DATA_W  instruction word, sampled with `run` in T0.
- `done`  out  1  high for exactly the final cycle of each instruction.
- `bus`  out  DATA_W  current value driven onto the internal bus.
- `flag_z`, `flag_c`  out  1 each  present only with `PROC_FLAGS_EN`.

## Operation
- Instruction fields:
  - opcode `iin[DATA_W-1 -: 3]`
  - Rx `iin[DATA_W-4 -: REG_AW]`
  - Ry `iin[DATA_W-4-REG_AW -: REG_AW]`
  - immediate: low `DATA_W-3-REG_AW` bits, zero-extended.
- Opcodes:
  - 000 mv Rx←Ry
  - 001 add Rx←Rx+Ry
  - 010 sub Rx←Rx−Ry
  - 011 and
  - 100 out (bus←Rx)
  - 101 mvi Rx←imm
  - 110 or
  - 111 xor
- FSM states T0..T3:
  - T0: idle/fetch, bus=0. If `run`, IR←iin, go T1; else stay.
  - T1, mv: bus=Ry, Rx←bus, `done`, go T0.
  - T1, mvi: bus=imm, Rx←bus, `done`, go T0.
  - T1, out: bus=Rx, no register write, `done`, go T0.
  - T1, ALU ops: bus=Rx, A←bus, go T2.
  - T2: bus=Ry, G←A op bus, go T3.
  - T3: bus=G, Rx←bus, `done`, go T0.
- Arithmetic is modulo 2^DATA_W and unsigned. Logic ops are bitwise.
- Rx==Ry is legal. For example, add R2,R2 doubles R2, because A captures the value before the write.
- `run` and `iin` are ignored outside T0. A held `run` starts the next instruction in the T0 following `done`.
- Reset takes priority over everything:
  - all registers, A, G, IR and flags clear to 0
  - state←T0
  - `done`=0, `bus`=0 from the next edge
  - an instruction interrupted mid-operation is discarded, with no partial Rx write.

## Timing
- `done` and `bus` are combinational from state/IR/registers. There is no bus tri-state: the bus is a mux.
- Latency from the edge that samples `run`:
  - mv/mvi/out: `done` in the next cycle; Rx updated at the end of that cycle.
  - ALU ops: `done` in the 3rd cycle; Rx updated at its end.
- Minimum issue interval: 2 cycles for mv/mvi/out, 4 cycles for ALU ops (including T0).
- Reset values of all outputs: `done`=0, `bus`=0, `flag_z`=0, `flag_c`=0.

## Configuration
- `PROC_FLAGS_EN` defined:
  - `flag_z`/`flag_c` ports exist, updated at the T2→T3 edge of ALU ops only.
  - Z=1 when the result is 0.
  - C = add carry-out; for sub, the borrow (1 when Rx<Ry unsigned).
  - and/or/xor clear C.
  - mv/mvi/out leave flags unchanged.
- `PROC_FLAGS_EN` undefined: no flag ports and no flag registers. Otherwise identical.

## Structure
- Package `proc_pkg`: opcode localparams (`OP_MV`..`OP_XOR`), state encoding (`T0`..`T3`), and the field-offset helper constants derived from DATA_W/REG_AW.
- Sub-module `proc_alu`: combinational, parametrised by DATA_W. Takes A, B and the opcode; produces the result and carry/borrow. The top owns the FSM, register file, A, G and IR.

## Test plan
DATA_W=16, REG_CNT=8, flags enabled.
- Reset held 2 cycles, then `run`=1 with mvi R0,28 (0xA01C): `done` in cycle 2 with bus=0x001C; R0=28. Then mvi R1,10 (0xA40A) gives R1=10.
- add R0,R1 (0x2080): bus sequence 0x001C, 0x000A, 0x0026; `done` with T3; R0=0x0026, Z=0, C=0.
- sub R1,R0 (0x4400): R1=0xFFE4, C=1. Then xor R1,R1 (0xE480): R1=0, Z=1, C=0.
- out R0 (0x8000): bus=0x0026 for one cycle with `done`=1; no register changes. `run`=0 for 5 cycles: stays in T0, bus=0, `done`=0.
- Assert `resetn` during T2 of add R0,R1: R0 stays 0 (not 0x0026), state T0, all registers 0. Then mvi R3,5 executes normally.
- Build with REG_CNT=4, DATA_W=8: mvi R3,7 then add R3,R3, giving R3=14. Regression without `PROC_FLAGS_EN` yields identical register results.
